// File: rtl/sobel_scan_controller_pkg.sv
// Shared definitions for the Sobel scan controller: FSM encoding and coordinate width.
package sobel_scan_controller_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int COORD_W = 11;

endpackage

// File: rtl/sobel_line_buffer.sv
// One image row of pixels: combinational read, synchronous write, contents never reset.
module sobel_line_buffer
   import sobel_scan_controller_pkg::*;
#(
   parameter int WIDTH   = 768,
   parameter int PIXEL_W = 8,
   parameter int ADDR_W  = 10
) (
   input  logic               clk,
   input  logic               we,
   input  logic [ADDR_W-1:0]  addr,
   input  logic [PIXEL_W-1:0] wdata,
   output logic [PIXEL_W-1:0] rdata
);

   localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(WIDTH);

   logic [PIXEL_W-1:0] mem_q [WIDTH];
   logic               in_range;
   logic [AW-1:0]      idx;

   // The scan visits one column past the image edge; that column reads as zero.
   assign in_range = (addr < LIMIT);
   assign idx      = addr[AW-1:0];
   assign rdata    = in_range ? mem_q[idx] : '0;

   always_ff @(posedge clk) begin
      if (we && in_range) begin
         mem_q[idx] <= wdata;
      end
   end

endmodule

// File: rtl/sobel_scan_controller.sv
// Frame sequencer for the Sobel datapath: builds zero-padded 3x3 windows from a raster
// pixel stream using two line buffers, then hands the frame buffer over for write-back.
module sobel_scan_controller
   import sobel_scan_controller_pkg::*;
#(
   parameter int WIDTH          = 768,
   parameter int HEIGHT         = 512,
   parameter int BITS_FOR_INDEX = 10,
   parameter int PIXEL_W        = 8
) (
   input  logic               CAMERA_CLK,
   input  logic               HRESETn,
   input  logic               start,
   input  logic               abort,
   input  logic               pix_valid,
   input  logic [PIXEL_W-1:0] pix_data,
   output logic               pix_ready,
   output logic               win_valid,
   output logic [PIXEL_W-1:0] ul,
   output logic [PIXEL_W-1:0] uc,
   output logic [PIXEL_W-1:0] ur,
   output logic [PIXEL_W-1:0] ml,
   output logic [PIXEL_W-1:0] mc,
   output logic [PIXEL_W-1:0] mr,
   output logic [PIXEL_W-1:0] dl,
   output logic [PIXEL_W-1:0] dc,
   output logic [PIXEL_W-1:0] dr,
   output logic [COORD_W-1:0] coordinate_X,
   output logic [COORD_W-1:0] coordinate_Y,
   output logic               readWrite,
   input  logic               writeDone,
   output logic               busy,
   output logic               done
);

   localparam int B = BITS_FOR_INDEX;
   localparam logic [B-1:0] W_IDX  = B'(WIDTH);
   localparam logic [B-1:0] H_IDX  = B'(HEIGHT);
   localparam logic [B-1:0] W_LAST = B'(WIDTH - 1);
   localparam logic [B-1:0] H_LAST = B'(HEIGHT - 1);
   localparam logic [B-1:0] ONE    = B'(1);
   localparam logic [B-1:0] ZERO   = '0;

   state_t             state_q;
   logic [B-1:0]       row_q, col_q;
   logic [PIXEL_W-1:0] win_q [9];
   logic [PIXEL_W-1:0] out_q [9];
   logic               win_valid_q;
   logic [COORD_W-1:0] cx_q, cy_q;

   logic               real_pos, adv, emit, lb_we;
   logic [PIXEL_W-1:0] in_px, lb0_rd, lb1_rd;
   logic [B-1:0]       cr, cc;
   logic [PIXEL_W-1:0] win_d [9];
   logic [PIXEL_W-1:0] out_d [9];

   // Window index i = 3*row + col, rows u/m/d and columns l/c/r.
   always_comb begin
      real_pos = (row_q < H_IDX) && (col_q < W_IDX);
      adv      = (state_q == SCAN) && (!real_pos || pix_valid);
      emit     = adv && (row_q != ZERO) && (col_q != ZERO);
      in_px    = real_pos ? pix_data : '0;
      lb_we    = adv && (col_q < W_IDX);
      cr       = row_q - ONE;
      cc       = col_q - ONE;
      for (int r = 0; r < 3; r++) begin
         win_d[3*r]   = win_q[3*r+1];
         win_d[3*r+1] = win_q[3*r+2];
         win_d[3*r+2] = '0;
      end
      win_d[2] = lb0_rd;
      win_d[5] = lb1_rd;
      win_d[8] = in_px;
      for (int i = 0; i < 9; i++) begin
         out_d[i] = win_d[i];
         if ((i < 3 && cr == ZERO) || (i >= 6 && cr == H_LAST) ||
             (i % 3 == 0 && cc == ZERO) || (i % 3 == 2 && cc == W_LAST)) begin
            out_d[i] = '0;
         end
      end
   end

   sobel_line_buffer #(.WIDTH(WIDTH), .PIXEL_W(PIXEL_W), .ADDR_W(B)) u_lb0 (
      .clk   (CAMERA_CLK),
      .we    (lb_we),
      .addr  (col_q),
      .wdata (lb1_rd),
      .rdata (lb0_rd)
   );

   sobel_line_buffer #(.WIDTH(WIDTH), .PIXEL_W(PIXEL_W), .ADDR_W(B)) u_lb1 (
      .clk   (CAMERA_CLK),
      .we    (lb_we),
      .addr  (col_q),
      .wdata (in_px),
      .rdata (lb1_rd)
   );

   always_ff @(posedge CAMERA_CLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q     <= IDLE;
         row_q       <= '0;
         col_q       <= '0;
         win_valid_q <= 1'b0;
         cx_q        <= '0;
         cy_q        <= '0;
         for (int i = 0; i < 9; i++) begin
            win_q[i] <= '0;
            out_q[i] <= '0;
         end
      end else begin
         win_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= SCAN;
                  row_q   <= '0;
                  col_q   <= '0;
               end
            end
            SCAN: begin
               if (adv) begin
                  for (int i = 0; i < 9; i++) begin
                     win_q[i] <= win_d[i];
                  end
                  if (col_q == W_IDX) begin
                     col_q <= '0;
                     if (row_q == H_IDX) begin
                        state_q <= WRITE;
                     end else begin
                        row_q <= row_q + ONE;
                     end
                  end else begin
                     col_q <= col_q + ONE;
                  end
               end
               if (emit) begin
                  win_valid_q <= 1'b1;
                  cx_q        <= COORD_W'(cr);
                  cy_q        <= COORD_W'(cc);
                  for (int i = 0; i < 9; i++) begin
                     out_q[i] <= out_d[i];
                  end
               end
            end
            WRITE: begin
               if (writeDone) begin
                  state_q <= DONE;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
         if (abort) begin
            state_q     <= IDLE;
            win_valid_q <= 1'b0;
         end
      end
   end

   assign pix_ready    = (state_q == SCAN) && real_pos;
   assign win_valid    = win_valid_q;
   assign busy         = (state_q != IDLE);
   assign done         = (state_q == DONE);
   assign readWrite    = (state_q != WRITE);
   assign coordinate_X = cx_q;
   assign coordinate_Y = cy_q;
   assign ul = out_q[0];
   assign uc = out_q[1];
   assign ur = out_q[2];
   assign ml = out_q[3];
   assign mc = out_q[4];
   assign mr = out_q[5];
   assign dl = out_q[6];
   assign dc = out_q[7];
   assign dr = out_q[8];

endmodule

// File: tb/tb_sobel_scan_controller.sv
// Self-checking bench for sobel_scan_controller on a 4x3 image against a window model.
module tb_sobel_scan_controller;

   localparam int W = 4;
   localparam int H = 3;
   localparam int N = W * H;

   logic        clk = 1'b0;
   logic        HRESETn = 1'b0;
   logic        start = 1'b0, abort = 1'b0, pix_valid = 1'b0, writeDone = 1'b0;
   logic [7:0]  pix_data = 8'd0;
   logic        pix_ready, win_valid, readWrite, busy, done;
   logic [7:0]  ul, uc, ur, ml, mc, mr, dl, dc, dr;
   logic [10:0] coordinate_X, coordinate_Y;

   int n_cmp = 0;
   int n_fail = 0;

   typedef struct {
      int          x;
      int          y;
      logic [71:0] px;
   } win_t;

   win_t       obs [$];
   int         done_cnt;
   logic [7:0] img [N];

   sobel_scan_controller #(.WIDTH(W), .HEIGHT(H), .BITS_FOR_INDEX(10), .PIXEL_W(8)) dut (
      .CAMERA_CLK(clk), .HRESETn(HRESETn), .start(start), .abort(abort),
      .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
      .win_valid(win_valid),
      .ul(ul), .uc(uc), .ur(ur), .ml(ml), .mc(mc), .mr(mr), .dl(dl), .dc(dc), .dr(dr),
      .coordinate_X(coordinate_X), .coordinate_Y(coordinate_Y),
      .readWrite(readWrite), .writeDone(writeDone), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      win_t w;
      if (win_valid) begin
         w.x  = int'(coordinate_X);
         w.y  = int'(coordinate_Y);
         w.px = {ul, uc, ur, ml, mc, mr, dl, dc, dr};
         obs.push_back(w);
      end
      if (done) done_cnt++;
   end

   function automatic logic [7:0] ref_px(input int r, input int c);
      if (r < 0 || r >= H || c < 0 || c >= W) return 8'd0;
      return img[r*W + c];
   endfunction

   function automatic logic [71:0] ref_win(input int r, input int c);
      logic [71:0] w;
      w = '0;
      for (int i = 0; i < 9; i++) w[(8-i)*8 +: 8] = ref_px(r + i/3 - 1, c + i%3 - 1);
      return w;
   endfunction

   task automatic gen_img(input bit ramp);
      for (int i = 0; i < N; i++) img[i] = ramp ? 8'(i + 1) : 8'($urandom_range(1, 255));
   endtask

   // mode 0: valid always, 1: alternating, 2: random. stop_after >= 0 leaves mid-frame.
   task automatic stream(input int mode, input bit start_mid, input int stop_after,
                         output int cycles);
      int idx;
      bit stall, pv;
      idx = 0; stall = 0; cycles = 0;
      obs.delete();
      done_cnt = 0;
      while (cycles < 200) begin
         @(negedge clk);
         if (stall) begin
            n_cmp++;
            if (win_valid !== 1'b0) begin
               n_fail++;
               $display("FAIL stall_win_valid: got %b want 0 at cycle %0d", win_valid, cycles);
            end
         end
         if (!readWrite) break;
         if (stop_after >= 0 && idx == stop_after) break;
         pv = (mode == 0) ? 1'b1 : (mode == 1) ? (cycles % 2 == 0) : 1'($urandom_range(0, 1));
         pix_valid = pv;
         pix_data  = (idx < N) ? img[idx] : 8'($urandom);
         start     = (cycles == 0) || (start_mid && cycles == 6);
         if (pv && pix_ready) begin
            if (idx >= N) begin
               n_cmp++; n_fail++;
               $display("FAIL extra_accept: pix_ready=1 after %0d pixels, want 0", idx);
            end else begin
               idx++;
            end
         end
         stall = pix_ready && !pv;
         cycles++;
      end
      pix_valid = 1'b0;
      start = 1'b0;
      if (cycles >= 200) begin
         n_cmp++; n_fail++;
         $display("FAIL stream_timeout: %0d cycles without reaching write-back", cycles);
      end
      if (stop_after < 0) begin
         n_cmp++;
         if (idx != N) begin
            n_fail++;
            $display("FAIL accept_count: got %0d want %0d", idx, N);
         end
      end
   endtask

   task automatic write_back();
      n_cmp++;
      if ({readWrite, busy} !== 2'b01) begin
         n_fail++;
         $display("FAIL wb_entry: readWrite,busy got %b want 01", {readWrite, busy});
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({readWrite, done, busy} !== 3'b001) begin
            n_fail++;
            $display("FAIL wb_wait: readWrite,done,busy got %b want 001", {readWrite, done, busy});
         end
      end
      writeDone = 1'b1;
      @(negedge clk);
      writeDone = 1'b0;
      n_cmp++;
      if ({readWrite, done, busy} !== 3'b111) begin
         n_fail++;
         $display("FAIL wb_done: readWrite,done,busy got %b want 111", {readWrite, done, busy});
      end
      @(negedge clk);
      n_cmp++;
      if ({readWrite, done, busy} !== 3'b100) begin
         n_fail++;
         $display("FAIL wb_idle: readWrite,done,busy got %b want 100", {readWrite, done, busy});
      end
      n_cmp++;
      if (done_cnt != 1) begin
         n_fail++;
         $display("FAIL done_pulses: got %0d want 1", done_cnt);
      end
   endtask

   task automatic check_windows(input string name);
      logic [71:0] exp_px;
      n_cmp++;
      if (obs.size() != N) begin
         n_fail++;
         $display("FAIL %s_win_count: got %0d want %0d", name, obs.size(), N);
      end
      for (int k = 0; k < obs.size() && k < N; k++) begin
         exp_px = ref_win(k / W, k % W);
         n_cmp++;
         if (obs[k].x != k / W || obs[k].y != k % W || obs[k].px !== exp_px) begin
            n_fail++;
            $display("FAIL %s_win%0d: got (%0d,%0d) %h want (%0d,%0d) %h", name, k,
                     obs[k].x, obs[k].y, obs[k].px, k / W, k % W, exp_px);
         end
      end
   endtask

   task automatic check_reset_outputs(input string name);
      n_cmp++;
      if ({pix_ready, win_valid, done, busy, readWrite} !== 5'b00001 ||
          coordinate_X !== 11'd0 || coordinate_Y !== 11'd0 ||
          {ul, uc, ur, ml, mc, mr, dl, dc, dr} !== 72'd0) begin
         n_fail++;
         $display("FAIL %s: ctl=%b X=%0d Y=%0d win=%h want ctl=00001 X=0 Y=0 win=0", name,
                  {pix_ready, win_valid, done, busy, readWrite}, coordinate_X, coordinate_Y,
                  {ul, uc, ur, ml, mc, mr, dl, dc, dr});
      end
   endtask

   task automatic full_frame(input int mode, input bit start_mid, input string name);
      int cyc;
      stream(mode, start_mid, -1, cyc);
      write_back();
      check_windows(name);
   endtask

   task automatic test_reset();
      #2;
      check_reset_outputs("reset_values");
      @(negedge clk);
      HRESETn = 1'b1;
      @(negedge clk);
      check_reset_outputs("post_reset_idle");
   endtask

   task automatic test_full_frame();
      int cyc;
      logic [71:0] want [3];
      int          pos [3];
      gen_img(1'b1);
      stream(0, 1'b0, -1, cyc);
      n_cmp++;
      if (cyc != 21) begin
         n_fail++;
         $display("FAIL scan_length: got %0d cycles want 21", cyc);
      end
      write_back();
      check_windows("full");
      want[0] = 72'h00_00_00_00_01_02_00_05_06; pos[0] = 0;
      want[1] = 72'h01_02_03_05_06_07_09_0a_0b; pos[1] = 5;
      want[2] = 72'h07_08_00_0b_0c_00_00_00_00; pos[2] = 11;
      for (int i = 0; i < 3; i++) begin
         if (obs.size() > pos[i]) begin
            n_cmp++;
            if (obs[pos[i]].px !== want[i]) begin
               n_fail++;
               $display("FAIL ramp_win%0d: got %h want %h", pos[i], obs[pos[i]].px, want[i]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      gen_img(1'b0);
      full_frame(1, 1'b0, "toggle");
      gen_img(1'b0);
      full_frame(2, 1'b0, "random_stall");
   endtask

   task automatic test_start_busy();
      gen_img(1'b0);
      full_frame(0, 1'b1, "start_busy");
   endtask

   task automatic test_abort();
      int cyc;
      gen_img(1'b0);
      stream(0, 1'b0, 5, cyc);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      n_cmp++;
      if ({busy, win_valid, done, readWrite} !== 4'b0001) begin
         n_fail++;
         $display("FAIL abort_idle: busy,win_valid,done,readWrite got %b want 0001",
                  {busy, win_valid, done, readWrite});
      end
      repeat (3) @(negedge clk);
      n_cmp++;
      if (done_cnt != 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_no_done: done pulses %0d busy %b want 0 0", done_cnt, busy);
      end
      gen_img(1'b1);
      full_frame(0, 1'b0, "after_abort");
   endtask

   task automatic test_async_reset();
      int cyc;
      gen_img(1'b0);
      stream(0, 1'b0, 7, cyc);
      #2;
      HRESETn = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      @(negedge clk);
      HRESETn = 1'b1;
      gen_img(1'b0);
      full_frame(0, 1'b0, "after_reset");
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_backpressure();
      test_start_busy();
      test_abort();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
